// File: rtl/n64_response_sequencer.sv
// n64_response_sequencer
// Streams a latched multi-byte controller response through the byte transmitter,
// one byte at a time, then requests the console stop bit. Owns both transmitter triggers.
// Optional feature: define N64_RESP_CRC_EN to append a CRC-8 byte (poly 0x85, init 0x00,
// MSB-first) after the payload bytes and before the stop bit.
module n64_response_sequencer #(
  parameter int unsigned MAX_BYTES   = 4,
  parameter int unsigned ACK_TIMEOUT = 15,
  localparam int unsigned LEN_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LEN_W-1:0]       length,
  input  logic [8*MAX_BYTES-1:0] payload,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   tx_trigger,
  output logic [7:0]             tx_byte,
  input  logic                   tx_busy,
  output logic                   stop_trigger,
  input  logic                   stop_busy
);

  localparam int unsigned TIMER_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StTrig,
    StAck,
    StWait,
    StStopTrig,
    StStopAck,
    StStopWait,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [LEN_W-1:0]       idx_q, idx_d;
  logic [LEN_W-1:0]       count_q, count_d;
  logic [8*MAX_BYTES-1:0] payload_q, payload_d;
  logic [7:0]             tx_byte_q, tx_byte_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic                   error_q, error_d;
  logic [LEN_W-1:0]       len_clamped;
  logic [7:0]             cur_byte;

`ifdef N64_RESP_CRC_EN
  logic [7:0] crc_q, crc_d;
  logic       crc_sent_q, crc_sent_d;

  // One CRC-8 byte update, MSB first, no reflection.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int b = 0; b < 8; b++) begin
      c = c[7] ? ((c << 1) ^ 8'h85) : (c << 1);
    end
    return c;
  endfunction
`endif

  // Clamp by compare so oversized lengths saturate instead of wrapping.
  assign len_clamped = (length > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : length;

  // Select byte[idx]; byte 0 sits in the most significant lane.
  always_comb begin
    cur_byte = 8'h00;
    for (int i = 0; i < int'(MAX_BYTES); i++) begin
      if (idx_q == LEN_W'(i)) begin
        cur_byte = payload_q[8*(int'(MAX_BYTES)-1-i) +: 8];
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    payload_d = payload_q;
    tx_byte_d = tx_byte_q;
    timer_d   = timer_q;
    error_d   = 1'b0;
`ifdef N64_RESP_CRC_EN
    crc_d      = crc_q;
    crc_sent_d = crc_sent_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          payload_d = payload;
          count_d   = len_clamped;
          idx_d     = '0;
`ifdef N64_RESP_CRC_EN
          crc_d      = 8'h00;
          crc_sent_d = 1'b0;
`endif
          state_d   = StLoad;
        end
      end
      StLoad: begin
        if (idx_q < count_q) begin
          tx_byte_d = cur_byte;
`ifdef N64_RESP_CRC_EN
          crc_d     = crc8_step(crc_q, cur_byte);
`endif
          state_d   = StTrig;
        end
`ifdef N64_RESP_CRC_EN
        else if (!crc_sent_q) begin
          tx_byte_d  = crc_q;
          crc_sent_d = 1'b1;
          state_d    = StTrig;
        end
`endif
        else begin
          state_d = StStopTrig;
        end
      end
      StTrig: begin
        timer_d = '0;
        state_d = StAck;
      end
      StAck: begin
        if (tx_busy) begin
          state_d = StWait;
        end else if (timer_q == TIMER_W'(ACK_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StWait: begin
        if (!tx_busy) begin
          // Saturate at count so the CRC pass cannot wrap idx back into range.
          if (idx_q < count_q) begin
            idx_d = idx_q + 1'b1;
          end
          state_d = StLoad;
        end
      end
      StStopTrig: begin
        timer_d = '0;
        state_d = StStopAck;
      end
      StStopAck: begin
        if (stop_busy) begin
          state_d = StStopWait;
        end else if (timer_q == TIMER_W'(ACK_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StStopWait: begin
        if (!stop_busy) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      count_q   <= '0;
      payload_q <= '0;
      tx_byte_q <= 8'h00;
      timer_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      payload_q <= payload_d;
      tx_byte_q <= tx_byte_d;
      timer_q   <= timer_d;
      error_q   <= error_d;
    end
  end

`ifdef N64_RESP_CRC_EN
  // CRC accumulator registers.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      crc_q      <= 8'h00;
      crc_sent_q <= 1'b0;
    end else begin
      crc_q      <= crc_d;
      crc_sent_q <= crc_sent_d;
    end
  end
`endif

  // Outputs decode straight from state so reset clears them without waiting for a clock.
  always_comb begin
    tx_trigger   = (state_q == StTrig);
    stop_trigger = (state_q == StStopTrig);
    done         = (state_q == StDone);
    busy         = (state_q != StIdle) && (state_q != StDone);
    error        = error_q;
    tx_byte      = tx_byte_q;
  end

endmodule
